// File: rtl/serial_addsub_acc_pkg.sv
// Shared types for the bit-serial accumulating adder/subtractor.
//   op_e    : opcode encoding carried on in_op
//   state_e : control FSM states
package serial_addsub_acc_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_LOAD = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/serial_addsub_acc_fa.sv
// 1-bit full-adder cell used as the serial datapath.
//   x, y, z : addend bits and carry in
//   sum     : x ^ y ^ z
//   carry   : majority(x, y, z)
module full_adder (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic sum,
    output logic carry
);

    assign sum   = x ^ y ^ z;
    assign carry = (x & y) | (z & (x ^ y));

endmodule

// File: rtl/serial_addsub_acc.sv
// Bit-serial accumulating adder/subtractor. One operand bit is combined with
// the accumulator per clock through a single full-adder cell.
//   clk, rst             : clock (rising edge), async active-high reset
//   in_valid/in_ready    : operand handshake, in_op opcode, in_b operand
//   out_valid/out_ready  : result handshake
//   acc                  : registered accumulator, always visible
//   flag_c/v/z/n         : carry, signed overflow, zero, negative
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | in_ready high, waiting for an operand
// RUN   | one full-adder step per clock, LSB first, WIDTH steps
// DONE  | out_valid high, acc and flags frozen until out_ready
module serial_addsub_acc
    import serial_addsub_acc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_e           state;
    state_e           state_next;
    op_e              op_in;
    logic             sub_sel;
    logic             arith_sel;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] bop;
    logic             carry;
    logic [CW-1:0]    idx;
    logic             bit_last;
    logic             fa_sum;
    logic             fa_carry;

    assign op_in     = op_e'(in_op);
    assign sub_sel   = (op_in == OP_SUB);
    assign arith_sel = (op_in == OP_ADD) || (op_in == OP_SUB);
    assign bit_last  = (idx == LAST_IDX);

    // Sum enters at the MSB while the accumulator copy drains from the LSB,
    // so after WIDTH steps the register holds the complete result.
    assign shift_next = {fa_sum, shift[WIDTH-1:1]};

    full_adder u_fa (
        .x     (shift[0]),
        .y     (bop[idx]),
        .z     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = arith_sel ? RUN : DONE;
                end
            end
            RUN: begin
                if (bit_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            shift  <= '0;
            bop    <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        case (op_in)
                            OP_ADD, OP_SUB: begin
                                // Two's complement subtract: invert B, carry-in 1.
                                bop   <= in_b ^ {WIDTH{sub_sel}};
                                carry <= sub_sel;
                                idx   <= '0;
                                shift <= acc;
                            end
                            OP_LOAD: begin
                                acc    <= in_b;
                                flag_c <= 1'b0;
                                flag_v <= 1'b0;
                                flag_z <= (in_b == '0);
                                flag_n <= in_b[WIDTH-1];
                            end
                            default: begin
                                acc    <= '0;
                                flag_c <= 1'b0;
                                flag_v <= 1'b0;
                                flag_z <= 1'b1;
                                flag_n <= 1'b0;
                            end
                        endcase
                    end
                end
                RUN: begin
                    shift <= shift_next;
                    carry <= fa_carry;
                    if (bit_last) begin
                        // carry still holds the carry into the MSB on this step.
                        acc    <= shift_next;
                        flag_c <= fa_carry;
                        flag_v <= carry ^ fa_carry;
                        flag_z <= (shift_next == '0);
                        flag_n <= fa_sum;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_acc.sv
module tb_serial_addsub_acc;

    localparam int W = 4;
    localparam int MOD = 1 << W;
    localparam int SMAX = (1 << (W - 1)) - 1;
    localparam int SMIN = -(1 << (W - 1));

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] acc;
    logic         flag_c, flag_v, flag_z, flag_n;

    serial_addsub_acc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_z    (flag_z),
        .flag_n    (flag_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] acc;
        logic         c, v, z, n;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   model_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int to_signed(input int u);
        return (u > SMAX) ? u - MOD : u;
    endfunction

    // Reference model: plain integer arithmetic on the accumulator value.
    function automatic exp_t model(input logic [1:0] op, input int a, input int b);
        exp_t e;
        int   full, res, sr;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            2'b00: begin
                full = a + b;
                res  = full % MOD;
                c    = (full >= MOD);
                sr   = to_signed(a) + to_signed(b);
                v    = (sr > SMAX) || (sr < SMIN);
            end
            2'b01: begin
                full = a + (MOD - 1 - b) + 1;
                res  = full % MOD;
                c    = (full >= MOD);
                sr   = to_signed(a) - to_signed(b);
                v    = (sr > SMAX) || (sr < SMIN);
            end
            2'b10: res = b;
            default: res = 0;
        endcase
        e.acc = W'(res);
        e.c = c;
        e.v = v;
        e.z = (res == 0);
        e.n = (res > SMAX);
        e.lat = (op[1] == 1'b0) ? W : 0;
        e.acc_cyc = 0;
        return e;
    endfunction

    // Monitor: compares each new DONE presentation against the scoreboard head.
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_ov <= 1'b0;
        end else begin
            check("valid_ready_excl", {31'd0, out_valid & in_ready}, 32'd0);
            if (out_valid && !prev_ov) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got acc=%0h with no op pending", acc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("acc", 32'(acc), 32'(e.acc));
                    check("flag_c", 32'(flag_c), 32'(e.c));
                    check("flag_v", 32'(flag_v), 32'(e.v));
                    check("flag_z", 32'(flag_z), 32'(e.z));
                    check("flag_n", 32'(flag_n), 32'(e.n));
                    check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                end
            end
            prev_ov <= out_valid;
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [W-1:0] b);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_op    = op;
        in_b     = b;
        e = model(op, model_acc, int'(b));
        e.acc_cyc = cyc + 1;
        sbq.push_back(e);
        model_acc = int'(e.acc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 2'($urandom);
        in_b     = W'($urandom);
    endtask

    task automatic expect_now(input logic [W-1:0] a, input logic c, input logic v,
                              input logic z, input logic n);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("dir_idle", 32'(in_ready), 32'd1);
        check("dir_acc", 32'(acc), 32'(a));
        check("dir_c", 32'(flag_c), 32'(c));
        check("dir_v", 32'(flag_v), 32'(v));
        check("dir_z", 32'(flag_z), 32'(z));
        check("dir_n", 32'(flag_n), 32'(n));
    endtask

    initial begin
        logic [W-1:0] acc_s;
        logic [3:0]   flags_s;
        int           guard;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_b      = '0;
        out_ready = 1'b1;
        #12;
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_flags", 32'({flag_c, flag_v, flag_z, flag_n}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed sequence from the test plan.
        do_op(2'b10, 4'b0101);
        expect_now(4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op(2'b00, 4'b0011);
        expect_now(4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);
        do_op(2'b01, 4'b1000);
        expect_now(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        do_op(2'b11, 4'b1010);
        do_op(2'b01, 4'b0001);
        expect_now(4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-pressure: hold DONE and wiggle inputs.
        out_ready = 1'b0;
        do_op(2'b00, W'($urandom));
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("bp_reach_done", 32'(out_valid), 32'd1);
        acc_s   = acc;
        flags_s = {flag_c, flag_v, flag_z, flag_n};
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_op    = 2'($urandom);
            in_b     = W'($urandom);
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_acc", 32'(acc), 32'(acc_s));
            check("bp_flags", 32'({flag_c, flag_v, flag_z, flag_n}), 32'(flags_s));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Async reset in the middle of RUN.
        do_op(2'b10, 4'b0001);
        do_op(2'b00, 4'b0111);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_acc", 32'(acc), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        sbq.delete();
        model_acc = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("post_rst_acc", 32'(acc), 32'd0);

        // Randomized operations.
        for (int i = 0; i < 60; i++) begin
            do_op(2'($urandom), W'($urandom));
        end

        guard = 0;
        while (sbq.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("drain", 32'(sbq.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
